// File: rtl/jtkunio_colmix.sv
// Kunio colour mixer: layer priority, CPU-writable 12-bit palette and blanked RGB output.
// Optional build macro JTKUNIO_LAYER_MASK_EN turns gfx_en into per-layer enables.
module jtkunio_colmix #(
  parameter int BLANK_DLY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [4:0] char_pxl,
  input  logic [5:0] scr_pxl,
  input  logic [4:0] obj_pxl,
  input  logic [2:0] gfx_en,
  input  logic [8:0] cpu_addr,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  // Bank 0 holds {G,R}, bank 1 holds {x,B}; both share the same 8-bit index.
  logic [7:0] pal_gr [0:255];
  logic [7:0] pal_b  [0:255];

  logic        cpu_we;
  logic [7:0]  cpu_gr_q;
  logic [7:0]  cpu_b_q;
  logic        cpu_bank_q;

  logic        char_opaque;
  logic        obj_opaque;
  logic [7:0]  scr_idx;
  logic [7:0]  sel_idx;

  logic [7:0]  idx_q;
  logic [11:0] rgb_q;
  logic [BLANK_DLY-1:0] lhbl_sr;
  logic [BLANK_DLY-1:0] lvbl_sr;
  logic        blank_ok;

  assign cpu_we = pal_cs & ~cpu_wrn;

  // CPU port: writes land in the bank picked by address bit 8.
  always_ff @(posedge clk) begin
    if (cpu_we && !cpu_addr[8]) pal_gr[cpu_addr[7:0]] <= cpu_dout;
    if (cpu_we &&  cpu_addr[8]) pal_b[cpu_addr[7:0]]  <= cpu_dout;
  end

  // CPU read-back runs every clock, independent of the pixel enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_gr_q   <= 8'h00;
      cpu_b_q    <= 8'h00;
      cpu_bank_q <= 1'b0;
    end else begin
      cpu_gr_q   <= pal_gr[cpu_addr[7:0]];
      cpu_b_q    <= pal_b[cpu_addr[7:0]];
      cpu_bank_q <= cpu_addr[8];
    end
  end

  assign cpu_din = cpu_bank_q ? cpu_b_q : cpu_gr_q;

  // Layer priority: char over obj over scroll; scroll is the opaque backdrop.
  always_comb begin
    char_opaque = (char_pxl[2:0] != 3'd0);
    obj_opaque  = (obj_pxl[2:0]  != 3'd0);
    scr_idx     = {2'b11, scr_pxl};
`ifdef JTKUNIO_LAYER_MASK_EN
    char_opaque = char_opaque & gfx_en[0];
    obj_opaque  = obj_opaque  & gfx_en[2];
    if (!gfx_en[1]) scr_idx = 8'hC0;
`endif
    if (char_opaque)     sel_idx = {3'b000, char_pxl};
    else if (obj_opaque) sel_idx = {3'b100, obj_pxl};
    else                 sel_idx = scr_idx;
  end

`ifndef JTKUNIO_LAYER_MASK_EN
  logic unused_gfx_en;
  assign unused_gfx_en = ^gfx_en;
`endif

  // Video pipeline: index register, then palette read (read-first against CPU writes).
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 8'h00;
      rgb_q   <= 12'h000;
      lhbl_sr <= '0;
      lvbl_sr <= '0;
    end else if (pxl_cen) begin
      idx_q      <= sel_idx;
      rgb_q      <= {pal_b[idx_q][3:0], pal_gr[idx_q]};
      lhbl_sr[0] <= LHBL;
      lvbl_sr[0] <= LVBL;
      for (int i = 1; i < BLANK_DLY; i++) begin
        lhbl_sr[i] <= lhbl_sr[i-1];
        lvbl_sr[i] <= lvbl_sr[i-1];
      end
    end
  end

  assign LHBL_dly = lhbl_sr[BLANK_DLY-1];
  assign LVBL_dly = lvbl_sr[BLANK_DLY-1];
  assign blank_ok = LHBL_dly & LVBL_dly;

  // The blank delay matches the pipeline depth, so gating uses the pixel's own blank.
  assign red   = blank_ok ? rgb_q[3:0]  : 4'h0;
  assign green = blank_ok ? rgb_q[7:4]  : 4'h0;
  assign blue  = blank_ok ? rgb_q[11:8] : 4'h0;

endmodule

// File: tb/tb_jtkunio_colmix.sv
// Directed bench for jtkunio_colmix: palette access, priority, latency, blanking, stall, reset.
module tb_jtkunio_colmix;

  logic       clk = 1'b0;
  logic       rst;
  logic       pxl_cen;
  logic       LHBL, LVBL;
  logic [4:0] char_pxl;
  logic [5:0] scr_pxl;
  logic [4:0] obj_pxl;
  logic [2:0] gfx_en;
  logic [8:0] cpu_addr;
  logic       pal_cs, cpu_wrn;
  logic [7:0] cpu_dout;
  logic [7:0] cpu_din;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  chr;
    logic [4:0]  obj;
    logic [5:0]  scr;
    logic [2:0]  gfx;
    logic        lh;
    logic        lv;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  jtkunio_colmix #(.BLANK_DLY(2)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .char_pxl(char_pxl), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl), .gfx_en(gfx_en),
    .cpu_addr(cpu_addr), .pal_cs(pal_cs), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rgb(input string name, input logic [11:0] exp);
    check(name, {20'd0, blue, green, red}, {20'd0, exp});
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dout = d;
    pal_cs   = 1'b1;
    cpu_wrn  = 1'b0;
    tick();
    pal_cs   = 1'b0;
    cpu_wrn  = 1'b1;
  endtask

  task automatic set_pxl(input logic [4:0] c, input logic [4:0] o, input logic [5:0] s);
    char_pxl = c;
    obj_pxl  = o;
    scr_pxl  = s;
  endtask

  task automatic add_vec(input logic [4:0] c, input logic [4:0] o, input logic [5:0] s,
                         input logic [2:0] g, input logic lh, input logic lv,
                         input logic [11:0] e);
    vecs[nv].chr = c;
    vecs[nv].obj = o;
    vecs[nv].scr = s;
    vecs[nv].gfx = g;
    vecs[nv].lh  = lh;
    vecs[nv].lv  = lv;
    vecs[nv].exp_rgb = e;
    nv++;
  endtask

  initial begin
    // expected colours as {B,G,R}
    add_vec(5'h01, 5'h02, 6'h05, 3'b111, 1, 1, 12'h321);
    add_vec(5'h08, 5'h0B, 6'h05, 3'b111, 1, 1, 12'hFFF);
    add_vec(5'h08, 5'h08, 6'h05, 3'b111, 1, 1, 12'h654);
    add_vec(5'h00, 5'h00, 6'h00, 3'b111, 1, 1, 12'h987);
    add_vec(5'h1F, 5'h0B, 6'h3F, 3'b111, 1, 1, 12'hCBA);
    add_vec(5'h00, 5'h00, 6'h3F, 3'b111, 1, 1, 12'h0ED);
    add_vec(5'h18, 5'h18, 6'h05, 3'b111, 1, 1, 12'h654);
    for (int i = 0; i < 12; i++) begin
      if (i >= 2 && i < 10) add_vec(5'h08, 5'h0B, 6'h05, 3'b111, 0, 1, 12'h000);
      else                  add_vec(5'h08, 5'h0B, 6'h05, 3'b111, 1, 1, 12'hFFF);
    end
    add_vec(5'h01, 5'h02, 6'h05, 3'b111, 1, 0, 12'h000);
    add_vec(5'h01, 5'h02, 6'h05, 3'b111, 0, 0, 12'h000);
`ifdef JTKUNIO_LAYER_MASK_EN
    add_vec(5'h01, 5'h0B, 6'h05, 3'b110, 1, 1, 12'hFFF);
    add_vec(5'h01, 5'h0B, 6'h05, 3'b000, 1, 1, 12'h987);
    add_vec(5'h00, 5'h00, 6'h05, 3'b101, 1, 1, 12'h987);
`else
    add_vec(5'h01, 5'h0B, 6'h05, 3'b110, 1, 1, 12'h321);
    add_vec(5'h01, 5'h0B, 6'h05, 3'b000, 1, 1, 12'h321);
    add_vec(5'h00, 5'h00, 6'h05, 3'b101, 1, 1, 12'h654);
`endif

    // reset
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; gfx_en = 3'b111;
    set_pxl(5'h00, 5'h00, 6'h00);
    cpu_addr = 9'h000; pal_cs = 1'b0; cpu_wrn = 1'b1; cpu_dout = 8'h00;
    repeat (3) tick();
    check_rgb("reset_rgb", 12'h000);
    check("reset_lhbl_dly", {31'd0, LHBL_dly}, 32'd0);
    check("reset_lvbl_dly", {31'd0, LVBL_dly}, 32'd0);
    check("reset_cpu_din", {24'd0, cpu_din}, 32'd0);
    rst = 1'b0;

    // CPU write then read-back, one clock of latency
    cpu_write(9'h010, 8'h5A);
    cpu_write(9'h110, 8'h03);
    cpu_addr = 9'h010; tick();
    check("cpu_rd_010", {24'd0, cpu_din}, 32'h5A);
    cpu_addr = 9'h110; tick();
    check("cpu_rd_110", {24'd0, cpu_din}, 32'h03);

    // palette contents used by the video vectors
    cpu_write(9'h001, 8'h21); cpu_write(9'h101, 8'h03);
    cpu_write(9'h08B, 8'hFF); cpu_write(9'h18B, 8'h0F);
    cpu_write(9'h0C5, 8'h54); cpu_write(9'h1C5, 8'h06);
    cpu_write(9'h0C0, 8'h87); cpu_write(9'h1C0, 8'h09);
    cpu_write(9'h01F, 8'hBA); cpu_write(9'h11F, 8'h0C);
    cpu_write(9'h0FF, 8'hED); cpu_write(9'h1FF, 8'h00);

    // table: output after edge k+1 belongs to the vector driven before edge k
    pxl_cen = 1'b1;
    for (int k = 0; k <= nv; k++) begin
      if (k < nv) begin
        set_pxl(vecs[k].chr, vecs[k].obj, vecs[k].scr);
        gfx_en = vecs[k].gfx;
        LHBL   = vecs[k].lh;
        LVBL   = vecs[k].lv;
      end
      tick();
      if (k >= 1) begin
        check_rgb($sformatf("vec%0d_rgb", k-1), vecs[k-1].exp_rgb);
        check($sformatf("vec%0d_lhbl", k-1), {31'd0, LHBL_dly}, {31'd0, vecs[k-1].lh});
        check($sformatf("vec%0d_lvbl", k-1), {31'd0, LVBL_dly}, {31'd0, vecs[k-1].lv});
      end
    end

    // stall: registers hold while pxl_cen is low
    gfx_en = 3'b111; LHBL = 1'b1; LVBL = 1'b1;
    set_pxl(5'h1F, 5'h00, 6'h00);
    tick(); tick();
    check_rgb("stall_pre", 12'hCBA);
    pxl_cen = 1'b0; LHBL = 1'b0;
    set_pxl(5'h01, 5'h00, 6'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_rgb($sformatf("stall_hold%0d", i), 12'hCBA);
      check($sformatf("stall_lhbl%0d", i), {31'd0, LHBL_dly}, 32'd1);
    end
    pxl_cen = 1'b1; LHBL = 1'b1;
    tick();
    check_rgb("stall_resume1", 12'hCBA);
    tick();
    check_rgb("stall_resume2", 12'h321);

    // same-cycle write/video read returns the old colour
    cpu_write(9'h001, 8'h77);
    check_rgb("collide_old", 12'h321);
    tick();
    check_rgb("collide_new", 12'h377);
    cpu_write(9'h001, 8'h21);
    tick();
    check_rgb("restore", 12'h321);

    // reset mid-line
    set_pxl(5'h08, 5'h0B, 6'h05);
    cpu_addr = 9'h010;
    tick(); tick();
    check_rgb("pre_rst_rgb", 12'hFFF);
    check("pre_rst_cpu_din", {24'd0, cpu_din}, 32'h5A);
    rst = 1'b1;
    tick();
    check_rgb("midrst_rgb", 12'h000);
    check("midrst_lhbl", {31'd0, LHBL_dly}, 32'd0);
    check("midrst_lvbl", {31'd0, LVBL_dly}, 32'd0);
    check("midrst_cpu_din", {24'd0, cpu_din}, 32'd0);
    rst = 1'b0;
    tick();
    check_rgb("post_rst1_rgb", 12'h000);
    check("post_rst1_cpu_din", {24'd0, cpu_din}, 32'h5A);
    tick();
    check_rgb("post_rst2_rgb", 12'hFFF);
    check("post_rst2_lhbl", {31'd0, LHBL_dly}, 32'd1);
    cpu_addr = 9'h110; tick();
    check("post_rst_rd_110", {24'd0, cpu_din}, 32'h03);
    cpu_addr = 9'h18B; tick();
    check("post_rst_rd_18b", {24'd0, cpu_din}, 32'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtkunio_colmix.md
# jtkunio_colmix

Colour mixer for the Kunio video path: takes the character, scroll and object pixel indices (the object index comes straight from the object line buffer read port) and resolves layer priority. It looks up a 12-bit RGB colour in a CPU-writable palette RAM and drives the final blanked RGB plus delayed blanking signals to the frame scaler. It sits directly downstream of the object renderer and is the last video stage before the frame wrapper.

## Interface
Parameters:
- `BLANK_DLY`, 2: pixel-clock delay applied to `LHBL`/`LVBL`. It must equal the colour pipeline depth.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `pxl_cen` in 1: pixel clock enable. The pipeline advances only on this.
- `LHBL` in 1: horizontal blank, active low.
- `LVBL` in 1: vertical blank, active low.
- `char_pxl` in 5: {pal[1:0], col[2:0]}; col 0 is transparent.
- `scr_pxl` in 6: {pal[2:0], col[2:0]}; always opaque.
- `obj_pxl` in 5: {pal[1:0], col[2:0]}; col 0 is transparent.
- `gfx_en` in 3: layer enables {obj, scr, char}. Only used with `JTKUNIO_LAYER_MASK_EN`.
- `cpu_addr` in 9: bit 8 selects the byte bank (0 = {G,R}, 1 = {x,B}); bits 7:0 are the palette index.
- `pal_cs` in 1: palette chip select.
- `cpu_wrn` in 1: write strobe, active low.
- `cpu_dout` in 8: CPU write data.
- `cpu_din` out 8: palette read data. One clock of latency after the address.
- `red`, `green`, `blue` out 4 each: final colour.
- `LHBL_dly`, `LVBL_dly` out 1: blanking delayed by `BLANK_DLY` pixels.

## Operation
- Palette RAM:
  - Two 256×8 dual-port banks. Port A serves the CPU: write when `pal_cs & ~cpu_wrn`; the bank is chosen by `cpu_addr[8]`.
  - Port B serves video and reads both banks at the same index.
  - On a same-cycle collision between a CPU write and a video read, port B returns the old data (read-first).
- Index map:
  - Character pixels use {3'b000, char_pxl} (0x00–0x1F).
  - Object pixels use {3'b100, obj_pxl} (0x80–0x9F).
  - Scroll pixels use {2'b11, scr_pxl} (0xC0–0xFF).
- Priority (stage 1):
  - If the char col is non-zero, the char pixel wins.
  - Otherwise, if the obj col is non-zero, the obj pixel wins.
  - Otherwise the scroll pixel wins.
- Pipeline, on each `pxl_cen`:
  - Stage 1 registers the selected 8-bit index.
  - Stage 2 registers the RAM output {B, G, R} (the RAM is addressed by the stage-1 register).
  - Outputs take stage 2 when both delayed blanks are 1, and 0 otherwise.
- `cpu_din` is muxed from the bank selected by the registered `cpu_addr[8]`.

## Timing
- Reset (`rst` = 1 on an edge):
  - `red`/`green`/`blue`, `LHBL_dly`, `LVBL_dly` and both stage registers clear to 0.
  - `cpu_din` clears to 0.
  - Palette RAM contents are untouched.
  - A reset mid-line discards in-flight pixels; output stays black until 2 `pxl_cen` after release.
- Latency:
  - A pixel presented on `pxl_cen` tick N appears on RGB at tick N+2.
  - `LHBL_dly`/`LVBL_dly` show tick-N blanking at tick N+2, so they stay aligned with the colour.
- Stall: with `pxl_cen` low, all video registers hold. CPU access runs every clock regardless of `pxl_cen`.
- Palette writes take effect for video indices read on the clock after the write edge.
- Blank edges: a pixel whose own delayed blank is 0 outputs 0, even if its RAM data is non-zero.

## Configuration
- `JTKUNIO_LAYER_MASK_EN` defined:
  - A layer whose `gfx_en` bit is 0 is treated as transparent. For scroll, this forces index 0xC0.
  - If all layers are disabled, the output is palette entry 0xC0.
- Undefined: `gfx_en` is ignored and all layers are always enabled.

## Test plan
- CPU writes 0x5A to addr 0x010 and 0x03 to addr 0x110, then reads both back → `cpu_din` = 0x5A, then 0x03, each one clock after its address.
- `char_pxl`=0x01, `obj_pxl`=0x02, `scr_pxl`=0x05, palette[0x01]={B3,G2,R1} → index 0x01; RGB = 1/2/3 exactly 2 `pxl_cen` later.
- `char_pxl`=0x08 (col 0), `obj_pxl`=0x0B, palette[0x8B]=0xFFF → RGB = F/F/F. Then `obj_pxl`=0x08 → scroll entry 0xC5 (`scr_pxl`=0x05) shown.
- Drive `LHBL`=0 for 8 pixels within non-zero pixel data → RGB = 0 and `LHBL_dly`=0 for exactly those 8 pixels, shifted by 2.
- Assert `rst` for 1 clock mid-line → next edge shows all outputs 0. The first non-zero RGB appears at the second `pxl_cen` after release, and earlier palette writes are still readable.
- With `JTKUNIO_LAYER_MASK_EN` and `gfx_en`=3'b110, opaque char 0x01 over obj 0x0B → the obj colour (palette 0x8B) is output. Without the macro → the char colour is output.
